// File: rtl/cr_kme_fifo_ctl.sv
// ---------------------------------------------------------------------------
// cr_kme_fifo_ctl
// KME staging FIFO. First-word-fall-through buffer between KME request
// producers and downstream key/engine consumers. It provides:
//   - a valid/ack read side, where the head entry is shown straight from storage
//   - an early-stall watermark plus a force-stall override
//   - a synchronous flush (clear)
//   - one-cycle overflow/underflow pulses, their sticky copies, and a
//     high-watermark monitor for CSR readback
//
// Ports
//   clk, rst_n              clock; synchronous active-low reset
//   clear                   synchronous flush; also clears sticky flags and max_used
//   fifo_in, fifo_in_valid  write data and write enable
//   fifo_in_stall_override  forces fifo_in_stall high
//   fifo_in_stall           advisory back-pressure to the producer
//   fifo_out, fifo_out_valid, fifo_out_ack
//                           head entry, not-empty flag, and pop request
//   used_slots, free_slots  current occupancy and DEPTH - occupancy
//   fifo_overflow           pulse: write while full with no pop
//   fifo_underflow          pulse: ack while empty
//   overflow_sticky, underflow_sticky
//                           latched copies of the pulses
//   max_used                highest occupancy seen since reset or clear
// ---------------------------------------------------------------------------
module cr_kme_fifo_ctl #(
    parameter int DATA_W       = 83,
    parameter int DEPTH        = 16,
    parameter int STALL_MARGIN = 0,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [DATA_W-1:0] fifo_in,
    input  logic              fifo_in_valid,
    input  logic              fifo_in_stall_override,
    output logic              fifo_in_stall,
    output logic [DATA_W-1:0] fifo_out,
    output logic              fifo_out_valid,
    input  logic              fifo_out_ack,
    output logic [CNT_W-1:0]  used_slots,
    output logic [CNT_W-1:0]  free_slots,
    output logic              fifo_overflow,
    output logic              fifo_underflow,
    output logic              overflow_sticky,
    output logic              underflow_sticky,
    output logic [CNT_W-1:0]  max_used
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  used_r;
    logic [CNT_W-1:0]  max_used_r;
    logic              ovf_sticky_r;
    logic              unf_sticky_r;

    logic              full_s;
    logic              empty_s;
    logic              wen_s;
    logic              ren_s;
    logic              ovf_s;
    logic              unf_s;
    logic [CNT_W-1:0]  free_s;
    logic [CNT_W-1:0]  used_nxt_s;

    // Occupancy decode, handshakes, error pulses and next count.
    always_comb begin
        full_s  = (used_r == CNT_W'(DEPTH));
        empty_s = (used_r == CNT_W'(0));
        free_s  = CNT_W'(DEPTH) - used_r;
        ren_s   = ~empty_s & fifo_out_ack;
        // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
        wen_s   = fifo_in_valid & (~full_s | ren_s);
        // Error pulses are suppressed while a flush or reset is being applied.
        ovf_s   = fifo_in_valid & full_s & ~ren_s & ~clear & rst_n;
        unf_s   = fifo_out_ack & empty_s & ~clear & rst_n;
        used_nxt_s = used_r;
        case ({wen_s, ren_s})
            2'b10:   used_nxt_s = used_r + CNT_W'(1);
            2'b01:   used_nxt_s = used_r - CNT_W'(1);
            default: used_nxt_s = used_r;
        endcase
    end

    // Payload storage. It has no reset because contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (wen_s && rst_n && !clear) begin
            mem_r[wr_ptr_r] <= fifo_in;
        end
    end

    // Pointers, count, sticky flags and high-watermark. Reset takes priority over clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r     <= PTR_W'(0);
            rd_ptr_r     <= PTR_W'(0);
            used_r       <= CNT_W'(0);
            max_used_r   <= CNT_W'(0);
            ovf_sticky_r <= 1'b0;
            unf_sticky_r <= 1'b0;
        end else if (clear) begin
            wr_ptr_r     <= PTR_W'(0);
            rd_ptr_r     <= PTR_W'(0);
            used_r       <= CNT_W'(0);
            max_used_r   <= CNT_W'(0);
            ovf_sticky_r <= 1'b0;
            unf_sticky_r <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (wen_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (ren_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            used_r       <= used_nxt_s;
            // The watermark tracks the registered count, so it trails it by one cycle.
            if (used_r > max_used_r) begin
                max_used_r <= used_r;
            end
            ovf_sticky_r <= ovf_sticky_r | ovf_s;
            unf_sticky_r <= unf_sticky_r | unf_s;
        end
    end

    // Output mapping. Stall is decoded from registered occupancy only.
    always_comb begin
        fifo_out         = mem_r[rd_ptr_r];
        fifo_out_valid   = ~empty_s;
        used_slots       = used_r;
        free_slots       = free_s;
        fifo_in_stall    = fifo_in_stall_override | (free_s <= CNT_W'(STALL_MARGIN));
        fifo_overflow    = ovf_s;
        fifo_underflow   = unf_s;
        overflow_sticky  = ovf_sticky_r;
        underflow_sticky = unf_sticky_r;
        max_used         = max_used_r;
    end

endmodule
